// File: rtl/layer2_seq_ctrl.sv
// layer2_seq_ctrl: time-multiplexes one shared 4-input MAC across NUM_NEURONS
// neurons. It holds a per-neuron weight table and latches one activation
// vector on start. For each neuron it issues the operands, captures the MAC
// sum one cycle later, and optionally applies ReLU. Each result is then
// returned over a valid/ready stream.
module layer2_seq_ctrl #(
    parameter int NUM_NEURONS = 4,
    parameter int AW          = $clog2(NUM_NEURONS),
    parameter bit RELU        = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [19:0]   wr_data,
    input  logic          start,
    input  logic [11:0]   in1,
    input  logic [11:0]   in2,
    input  logic [11:0]   in3,
    input  logic [11:0]   in4,
    output logic [11:0]   mac_in1,
    output logic [11:0]   mac_in2,
    output logic [11:0]   mac_in3,
    output logic [11:0]   mac_in4,
    output logic [4:0]    mac_w1,
    output logic [4:0]    mac_w2,
    output logic [4:0]    mac_w3,
    output logic [4:0]    mac_w4,
    input  logic [16:0]   mac_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [16:0]   res_data,
    output logic [AW-1:0] res_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {IDLE, ISSUE, CAPT, OUT, FIN} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(NUM_NEURONS);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [11:0]   act1, act2, act3, act4;
    logic [19:0]   wtab [NUM_NEURONS];
    logic [19:0]   wsel;
    logic [16:0]   relu_out;
    logic          wr_ok;

    // Writes land only while idle and only for a neuron that exists.
    assign wr_ok    = (state == IDLE) && wr_en && ({1'b0, wr_addr} < DEPTH);

    // Operands always reflect the latched activations and the current neuron's weights.
    assign wsel     = wtab[cnt];
    assign mac_in1  = act1;
    assign mac_in2  = act2;
    assign mac_in3  = act3;
    assign mac_in4  = act4;
    assign mac_w1   = wsel[4:0];
    assign mac_w2   = wsel[9:5];
    assign mac_w3   = wsel[14:10];
    assign mac_w4   = wsel[19:15];

    // Negative sums clip to zero only when ReLU is enabled; otherwise bit-exact.
    assign relu_out = (RELU && mac_out[16]) ? '0 : mac_out;

    // Weight table: written in IDLE (a write alongside start is seen by that pass).
    // NOTE: this memory is reset on purpose -- a pass after reset must see all-zero weights.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                wtab[i] <= '0;
            end
        end else if (wr_ok) begin
            wtab[wr_addr] <= wr_data;
        end
    end

    // Sequencer FSM: issue, capture, hand off each neuron's result, then pulse done.
    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            act1      <= '0;
            act2      <= '0;
            act3      <= '0;
            act4      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        act1  <= in1;
                        act2  <= in2;
                        act3  <= in3;
                        act4  <= in4;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The datapath registers the operands at the end of this cycle.
                    state <= CAPT;
                end
                CAPT: begin
                    res_data  <= relu_out;
                    res_idx   <= cnt;
                    res_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (cnt == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            cnt   <= cnt + AW'(1);
                            state <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/layer2_seq_ctrl.md
# layer2_seq_ctrl

Sequencer for the shared 4-input layer-2 MAC datapath: 4 × 12-bit signed activations, 4 × 5-bit signed weights, 17-bit signed sum, operands registered inside the datapath. It holds a per-neuron weight table, captures one activation vector on `start`, and time-multiplexes the single MAC across `NUM_NEURONS` neurons. Each result is optionally ReLU-clipped and returned over a valid/ready stream. It sits between the layer-1 output stage and the layer-2 result consumer.

## Interface
- `NUM_NEURONS`, 4: neurons in the layer (2..64).
- `AW`, $clog2(NUM_NEURONS): weight-table address width.
- `RELU`, 1: 1 = clip negative results to 0; 0 = pass through.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  weight-table write strobe.
- `wr_addr`  in  AW  neuron index to write.
- `wr_data`  in  20  packed weights, signed 5-bit each: w1=[4:0], w2=[9:5], w3=[14:10], w4=[19:15].
- `start`  in  1  begin one layer pass.
- `in1`..`in4`  in  12 each  signed activations, sampled when `start` is accepted.
- `mac_in1`..`mac_in4`  out  12 each  activation operands to the MAC.
- `mac_w1`..`mac_w4`  out  5 each  weight operands to the MAC.
- `mac_out`  in  17  signed MAC sum.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  17  signed result after optional ReLU.
- `res_idx`  out  AW  neuron index of `res_data`.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse after the last result is accepted.

## Operation
- FSM states: IDLE, ISSUE, CAPT, OUT, FIN.
- IDLE:
  - `start`=1 latches `in1`..`in4` into the activation registers, sets the neuron counter to 0, and moves to ISSUE.
  - `start` while not IDLE is ignored.
- ISSUE:
  - Drives `mac_in*` from the activation registers and `mac_w*` from the table entry for the current counter.
  - Moves to CAPT unconditionally.
- CAPT:
  - `mac_out` now reflects the operands issued in ISSUE. Register it, apply ReLU if `RELU`=1, and load `res_data` and `res_idx`.
  - Moves to OUT.
- OUT:
  - `res_valid`=1; `res_data` and `res_idx` are held stable until the handshake.
  - On `res_valid && res_ready`: if the counter equals `NUM_NEURONS`-1, go to FIN; otherwise increment the counter and go to ISSUE.
- FIN: pulse `done` for one cycle, then return to IDLE.
- Weight writes:
  - Accepted only in IDLE. `wr_en` in any other state is dropped and the table is unchanged.
  - A write and `start` in the same IDLE cycle are both honored. The pass uses the newly written entry.
- `mac_*` outputs are driven every cycle from the activation registers and the current-counter table entry. In IDLE they hold the last values and carry no meaning.
- Arithmetic:
  - The controller performs no addition.
  - `res_data` is `mac_out` bit-exact when `RELU`=0. When `RELU`=1 it is `mac_out` if `mac_out[16]`=0, else 0.
  - Overflow behavior belongs to the datapath; no saturation is applied here.
- `busy` = (state != IDLE).

## Timing
- Reset (async assert, sync release):
  - state IDLE; counter 0.
  - `res_valid`, `res_data`, `res_idx`, `busy`, `done`, and all `mac_*` outputs are 0.
  - Activation registers and the entire weight table are 0.
- Reset asserted mid-pass aborts the pass with no `done`. The next pass requires a new `start`.
- Per-neuron latency:
  - `start` edge → ISSUE in cycle 1 → CAPT in cycle 2 → `res_valid` in cycle 3.
  - With `res_ready` tied high, neurons issue every 3 cycles.
  - A full pass takes 3·N cycles, plus 1 for FIN, from the `start` edge to `done`.
- Backpressure: OUT holds indefinitely while `res_ready`=0. The MAC is not re-issued during the stall.
- `res_ready` asserted outside OUT has no effect.
- `start` in the FIN cycle is ignored. `start` is accepted from the first IDLE cycle onward.

## Test plan
- Basic pass, NUM_NEURONS=4, RELU=1:
  - Weights: n0=(1,2,3,4), n1=(-1,-1,-1,-1), n2=(0,0,0,0), n3=(15,-16,1,0). Start with in=(10,-3,7,1); `res_ready`=1.
  - Required results: idx0=29, idx1=0, idx2=0, idx3=205.
  - `done` on cycle 13 after `start`; `busy` high for cycles 1..13.
- RELU=0, same stimulus: idx1 must be -15 (17'h1FFF1). Other results unchanged.
- Backpressure: hold `res_ready`=0 for 5 cycles in each OUT. `res_data` and `res_idx` stay stable, no MAC re-issue occurs, and `done` is delayed by exactly 20 cycles.
- Write gating:
  - `wr_en` to addr 0 with weights (2,2,2,2) while `busy`; rerun the first scenario's inputs. idx0 must still be 29.
  - Repeat the same write in IDLE, together with `start`. idx0 must be 30.
- Reset mid-pass: assert `rst` while in OUT for idx 1. All outputs go to 0 immediately, with no `done` pulse. After release, a new `start` with zero weights yields four results of 0.
- Extreme operands: in=(-2048,-2048,0,0), n0=(-16,1,0,0). Required `res_data` = 30720 (32768-2048), bit-exact vs `mac_out`; `start` pulses while `busy` have no effect.
